// File: rtl/cart_pkg.sv
// Shared types and constants for cartridge bank-switch / SuperChip detection.
package cart_pkg;

  typedef enum logic [3:0] {
    BS_NONE = 4'd0,
    BS_F8   = 4'd1,
    BS_F6   = 4'd2,
    BS_FE   = 4'd3,
    BS_E0   = 4'd4,
    BS_3F   = 4'd5,
    BS_F4   = 4'd6,
    BS_P2   = 4'd7,
    BS_FA   = 4'd8,
    BS_CV   = 4'd9
  } bs_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DECIDE,
    ST_DONE
  } det_state_t;

  localparam logic [31:0] SZ_8K   = 32'd8192;
  localparam logic [31:0] SZ_10K  = 32'd10240;
  localparam logic [31:0] SZ_10K5 = 32'd10495;
  localparam logic [31:0] SZ_12K  = 32'd12288;
  localparam logic [31:0] SZ_16K  = 32'd16384;
  localparam logic [31:0] SZ_32K  = 32'd32768;

  // Signatures are matched with the most recent byte in the low byte lane.
  localparam logic [15:0] SIG_3F   = 16'h853F;
  localparam logic [23:0] SIG_E0_A = 24'h8DE01F;
  localparam logic [23:0] SIG_E0_B = 24'h8DE05F;
  localparam logic [23:0] SIG_E0_C = 24'h8DE9FF;
  localparam logic [23:0] SIG_E0_D = 24'hADE01F;
  localparam logic [39:0] SIG_FE   = 40'h2000D0C6C5;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/cart_bs_detect_if.sv
// ioctl download snoop inputs, override controls and resolved detection results.
interface cart_bs_detect_if #(
  parameter int ADDR_W = 17
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [3:0]        ext_bs;
  logic              ext_sc;
  logic [1:0]        sc_mode;
  logic [3:0]        force_bs;
  logic              sc;
  logic [ADDR_W-1:0] rom_size;
  logic              det_valid;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ext_bs, ext_sc, sc_mode,
    input  force_bs, sc, rom_size, det_valid
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ext_bs, ext_sc, sc_mode,
    output force_bs, sc, rom_size, det_valid
  );
endinterface

// File: rtl/cart_sig_match.sv
// Byte-history window plus saturating 3F/E0 hit counters and sticky FE flag.
// Counts update the cycle after a write; clr wins over wr.
module cart_sig_match
  import cart_pkg::*;
(
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr,
  input  logic [7:0] data,
  output logic [3:0] cnt_3f,
  output logic [3:0] cnt_e0,
  output logic       fe_hit
);

  logic [31:0] hist_q;
  logic [39:0] win;
  logic        hit_3f;
  logic        hit_e0;
  logic        hit_fe;

  // Five-byte window: four previous bytes plus the byte being written now.
  assign win    = {hist_q, data};
  assign hit_3f = (win[15:0] == SIG_3F);
  assign hit_e0 = (win[23:0] == SIG_E0_A) || (win[23:0] == SIG_E0_B) ||
                  (win[23:0] == SIG_E0_C) || (win[23:0] == SIG_E0_D);
  assign hit_fe = (win == SIG_FE);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      cnt_3f <= '0;
      cnt_e0 <= '0;
      fe_hit <= 1'b0;
    end else if (clr) begin
      hist_q <= '0;
      cnt_3f <= '0;
      cnt_e0 <= '0;
      fe_hit <= 1'b0;
    end else if (wr) begin
      hist_q <= win[31:0];
      if (hit_3f) cnt_3f <= sat_inc4(cnt_3f);
      if (hit_e0) cnt_e0 <= sat_inc4(cnt_e0);
      if (hit_fe) fe_hit <= 1'b1;
    end
  end

endmodule

// File: rtl/cart_bs_detect.sv
// Passive ioctl snooper: sizes the cartridge image, scans signatures, resolves force_bs/sc.
// Results and det_valid land 2 clk_sys cycles after ioctl_download falls; never stalls the stream.
module cart_bs_detect
  import cart_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int SIG_MIN  = 2,
  parameter int SC_BYTES = 256
) (
  input logic             clk_sys,
  input logic             reset,
  cart_bs_detect_if.slave io
);

  logic [1:0]        rst_sync_q;
  logic              rst;
  logic              dl_q;
  logic              rise;
  logic              fall;
  det_state_t        state_q;
  det_state_t        state_d;
  logic              start;
  logic              snoop_wr;
  logic              pend_q;
  logic [ADDR_W-1:0] max_addr_q;
  logic              any_wr_q;
  logic [7:0]        byte0_q;
  logic              b0_vld_q;
  logic              sc_ok_q;
  logic [3:0]        cnt_3f;
  logic [3:0]        cnt_e0;
  logic              fe_hit;
  logic [ADDR_W:0]   size_ext;
  logic [ADDR_W-1:0] size_d;
  logic [31:0]       size32;
  logic              sc_auto;
  bs_t               bs_d;
  logic              sc_d;
  bs_t               force_bs_q;
  logic              sc_q;
  logic [ADDR_W-1:0] rom_size_q;
  logic              det_valid_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst = rst_sync_q[1];

  // Reset value 1 hides a download already in flight, so only a fresh rising edge starts a snoop.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) dl_q <= 1'b1;
    else     dl_q <= io.ioctl_download;
  end
  assign rise = io.ioctl_download & ~dl_q;
  assign fall = ~io.ioctl_download & dl_q;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          start   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (fall) state_d = ST_DECIDE;
      end
      ST_DECIDE: state_d = ST_DONE;
      ST_DONE: begin
        if (rise || pend_q) begin
          start   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign snoop_wr = io.ioctl_wr && (state_q == ST_LOAD);

  cart_sig_match u_sig (
    .clk_sys (clk_sys),
    .rst     (rst),
    .clr     (start),
    .wr      (snoop_wr),
    .data    (io.ioctl_dout),
    .cnt_3f  (cnt_3f),
    .cnt_e0  (cnt_e0),
    .fe_hit  (fe_hit)
  );

  // A full 2^ADDR_W image cannot be represented, so it reports all-ones.
  assign size_ext = {1'b0, max_addr_q} + {{ADDR_W{1'b0}}, 1'b1};
  always_comb begin
    size_d = '0;
    if (any_wr_q) size_d = size_ext[ADDR_W] ? {ADDR_W{1'b1}} : size_ext[ADDR_W-1:0];
  end
  assign size32 = 32'(size_d);

  assign sc_auto = sc_ok_q && (size32 >= 32'(SC_BYTES)) &&
                   ((size32 == SZ_8K) || (size32 == SZ_16K) || (size32 == SZ_32K));

  always_comb begin
    bs_d = BS_NONE;
    if (io.ext_bs != 4'd0)                                     bs_d = bs_t'(io.ext_bs);
    else if (32'(cnt_3f) >= 32'(SIG_MIN))                      bs_d = BS_3F;
    else if ((size32 == SZ_8K) && (32'(cnt_e0) >= 32'(SIG_MIN))) bs_d = BS_E0;
    else if ((size32 == SZ_8K) && fe_hit)                      bs_d = BS_FE;
    else if (size32 == SZ_8K)                                  bs_d = BS_F8;
    else if ((size32 == SZ_10K) || (size32 == SZ_10K5))        bs_d = BS_P2;
    else if (size32 == SZ_12K)                                 bs_d = BS_FA;
    else if (size32 == SZ_16K)                                 bs_d = BS_F6;
    else if (size32 == SZ_32K)                                 bs_d = BS_F4;
  end

  always_comb begin
    sc_d = 1'b1;
    case (io.sc_mode)
      2'd0:    sc_d = io.ext_sc | sc_auto;
      2'd1:    sc_d = 1'b0;
      default: sc_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      pend_q      <= 1'b0;
      max_addr_q  <= '0;
      any_wr_q    <= 1'b0;
      byte0_q     <= '0;
      b0_vld_q    <= 1'b0;
      sc_ok_q     <= 1'b1;
      force_bs_q  <= BS_NONE;
      sc_q        <= 1'b0;
      rom_size_q  <= '0;
      det_valid_q <= 1'b0;
    end else begin
      if (start) begin
        pend_q      <= 1'b0;
        max_addr_q  <= '0;
        any_wr_q    <= 1'b0;
        b0_vld_q    <= 1'b0;
        sc_ok_q     <= 1'b1;
        det_valid_q <= 1'b0;
      end else begin
        if ((state_q == ST_DECIDE) && rise) pend_q <= 1'b1;
        if (snoop_wr) begin
          any_wr_q <= 1'b1;
          if (io.ioctl_addr > max_addr_q) max_addr_q <= io.ioctl_addr;
          // Bank-0 bytes arriving before byte 0 cannot be checked, so they disqualify SuperChip.
          if (32'(io.ioctl_addr) < 32'(SC_BYTES)) begin
            if (io.ioctl_addr == '0) begin
              byte0_q  <= io.ioctl_dout;
              b0_vld_q <= 1'b1;
            end else if (!b0_vld_q || (io.ioctl_dout != byte0_q)) begin
              sc_ok_q <= 1'b0;
            end
          end
        end
      end
      if (state_q == ST_DECIDE) begin
        force_bs_q  <= bs_d;
        sc_q        <= sc_d;
        rom_size_q  <= size_d;
        det_valid_q <= 1'b1;
      end
    end
  end

  assign io.force_bs  = force_bs_q;
  assign io.sc        = sc_q;
  assign io.rom_size  = rom_size_q;
  assign io.det_valid = det_valid_q;

endmodule

// File: tb/tb_cart_bs_detect.sv
// Scenario bench for cart_bs_detect against a scan-the-whole-image reference model.
module tb_cart_bs_detect;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  logic [7:0]  seq_dat  [0:32767];
  logic [16:0] seq_addr [0:32767];

  cart_bs_detect_if #(.ADDR_W(17)) bus ();

  cart_bs_detect #(.ADDR_W(17), .SIG_MIN(2), .SC_BYTES(256)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .io      (bus)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #5ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Filler avoids every signature lead byte (20, 85, 8D, AD).
  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    b = 8'($urandom_range(0, 126));
    if (b >= 8'h20) b = b + 8'd1;
    return b;
  endfunction

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      seq_addr[k] = 17'(k);
      seq_dat[k]  = rnd_byte();
    end
  endtask

  function automatic int byte_at(input int k);
    if (k < 0) return -1;
    return int'(seq_dat[k]);
  endfunction

  function automatic bit seq_match(input int k, input int len, input logic [39:0] pat);
    for (int j = 0; j < len; j++)
      if (byte_at(k - len + 1 + j) != int'(pat[8*(len-1-j) +: 8])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model(input int n, input int xbs, input int xsc, input int mode,
                       output int e_size, output int e_bs, output int e_sc);
    int maxa, c3f, ce0, b0;
    bit fe, ok, auto_sc, sz_ok;
    maxa = -1; c3f = 0; ce0 = 0; b0 = -1; fe = 0; ok = 1;
    for (int k = 0; k < n; k++) begin
      if (int'(seq_addr[k]) > maxa) maxa = int'(seq_addr[k]);
      if (seq_addr[k] == 17'd0) b0 = int'(seq_dat[k]);
      if (seq_match(k, 2, 40'h853F) && c3f < 15) c3f++;
      if ((seq_match(k, 3, 40'h8DE01F) || seq_match(k, 3, 40'h8DE05F) ||
           seq_match(k, 3, 40'h8DE9FF) || seq_match(k, 3, 40'hADE01F)) && ce0 < 15) ce0++;
      if (seq_match(k, 5, 40'h2000D0C6C5)) fe = 1;
    end
    for (int k = 0; k < n; k++)
      if (seq_addr[k] < 17'd256 && int'(seq_dat[k]) != b0) ok = 0;
    e_size = (n == 0) ? 0 : ((maxa + 1 > 131071) ? 131071 : maxa + 1);
    if (xbs != 0)                      e_bs = xbs;
    else if (c3f >= 2)                 e_bs = 5;
    else if (e_size == 8192 && ce0 >= 2) e_bs = 4;
    else if (e_size == 8192 && fe)     e_bs = 3;
    else if (e_size == 8192)           e_bs = 1;
    else if (e_size == 10240 || e_size == 10495) e_bs = 7;
    else if (e_size == 12288)          e_bs = 8;
    else if (e_size == 16384)          e_bs = 2;
    else if (e_size == 32768)          e_bs = 6;
    else                               e_bs = 0;
    sz_ok   = (e_size == 8192) || (e_size == 16384) || (e_size == 32768);
    auto_sc = ok && (e_size >= 256) && sz_ok;
    if (mode == 0)      e_sc = xsc ? 1 : int'(auto_sc);
    else if (mode == 1) e_sc = 0;
    else                e_sc = 1;
  endtask

  task automatic set_cfg(input int xbs, input int xsc, input int mode);
    bus.ext_bs  = 4'(xbs);
    bus.ext_sc  = 1'(xsc);
    bus.sc_mode = 2'(mode);
  endtask

  // Drives one download; dv1/dv2 are det_valid one and two cycles after the fall.
  task automatic drive_download(input int n, input bit fall_with_last, input bit rise_at_n1,
                                output logic dv1, output logic dv2);
    @(negedge clk_sys); bus.ioctl_download = 1'b1;
    repeat (3) @(negedge clk_sys);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_sys);
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = seq_addr[k];
      bus.ioctl_dout = seq_dat[k];
      if (fall_with_last && k == n - 1) bus.ioctl_download = 1'b0;
    end
    if (!(fall_with_last && n > 0)) begin
      @(negedge clk_sys); bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
    end
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = rise_at_n1;
    dv1 = bus.det_valid;
    @(negedge clk_sys);
    dv2 = bus.det_valid;
  endtask

  task automatic test_reset();
    bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0; bus.ioctl_dout = '0;
    set_cfg(0, 0, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);
    total++; if (bus.force_bs !== 4'd0) begin bad++; $display("FAIL reset_bs got=%0d exp=0", bus.force_bs); end
    total++; if (bus.sc !== 1'b0) begin bad++; $display("FAIL reset_sc got=%0b exp=0", bus.sc); end
    total++; if (bus.rom_size !== 17'd0) begin bad++; $display("FAIL reset_size got=%0d exp=0", bus.rom_size); end
    total++; if (bus.det_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%0b exp=0", bus.det_valid); end
  endtask

  task automatic test_back_to_back();
    int esz, ebs, esc;
    logic dv1, dv2;
    for (int k = 0; k < 8192; k++) begin seq_addr[k] = 17'(k); seq_dat[k] = 8'hEA; end
    seq_dat[0] = 8'h78;
    set_cfg(0, 0, 0);
    model(8192, 0, 0, 0, esz, ebs, esc);
    drive_download(8192, 1'b1, 1'b1, dv1, dv2);
    total++; if (dv1 !== 1'b0) begin bad++; $display("FAIL nop_dv1 got=%0b exp=0", dv1); end
    total++; if (dv2 !== 1'b1) begin bad++; $display("FAIL nop_dv2 got=%0b exp=1", dv2); end
    total++; if (bus.force_bs !== 4'(ebs)) begin bad++; $display("FAIL nop_bs got=%0d exp=%0d", bus.force_bs, ebs); end
    total++; if (bus.sc !== 1'(esc)) begin bad++; $display("FAIL nop_sc got=%0b exp=%0d", bus.sc, esc); end
    total++; if (bus.rom_size !== 17'(esz)) begin bad++; $display("FAIL nop_size got=%0d exp=%0d", bus.rom_size, esz); end
    @(negedge clk_sys);
    total++; if (bus.det_valid !== 1'b0) begin bad++; $display("FAIL defer_dv got=%0b exp=0", bus.det_valid); end
    fill_random(16384);
    set_cfg(3, 0, 1);
    model(16384, 3, 0, 1, esz, ebs, esc);
    drive_download(16384, 1'b0, 1'b0, dv1, dv2);
    total++; if (dv2 !== 1'b1) begin bad++; $display("FAIL ovr_dv got=%0b exp=1", dv2); end
    total++; if (bus.force_bs !== 4'(ebs)) begin bad++; $display("FAIL ovr_bs got=%0d exp=%0d", bus.force_bs, ebs); end
    total++; if (bus.sc !== 1'(esc)) begin bad++; $display("FAIL ovr_sc got=%0b exp=%0d", bus.sc, esc); end
    total++; if (bus.rom_size !== 17'(esz)) begin bad++; $display("FAIL ovr_size got=%0d exp=%0d", bus.rom_size, esz); end
  endtask

  task automatic test_e0_8k();
    int esz, ebs, esc;
    logic dv1, dv2;
    fill_random(8192);
    for (int k = 0; k < 256; k++) seq_dat[k] = 8'hFF;
    seq_dat[16'h400] = 8'h8D; seq_dat[16'h401] = 8'hE0; seq_dat[16'h402] = 8'h1F;
    seq_dat[16'h900] = 8'h8D; seq_dat[16'h901] = 8'hE0; seq_dat[16'h902] = 8'h1F;
    set_cfg(0, 0, 0);
    model(8192, 0, 0, 0, esz, ebs, esc);
    drive_download(8192, 1'b0, 1'b0, dv1, dv2);
    total++; if (dv1 !== 1'b0) begin bad++; $display("FAIL e0_dv1 got=%0b exp=0", dv1); end
    total++; if (dv2 !== 1'b1) begin bad++; $display("FAIL e0_dv2 got=%0b exp=1", dv2); end
    total++; if (bus.force_bs !== 4'(ebs)) begin bad++; $display("FAIL e0_bs got=%0d exp=%0d", bus.force_bs, ebs); end
    total++; if (bus.sc !== 1'(esc)) begin bad++; $display("FAIL e0_sc got=%0b exp=%0d", bus.sc, esc); end
    total++; if (bus.rom_size !== 17'(esz)) begin bad++; $display("FAIL e0_size got=%0d exp=%0d", bus.rom_size, esz); end
  endtask

  task automatic test_3f_4k();
    int esz, ebs, esc;
    logic dv1, dv2;
    fill_random(4096);
    seq_dat[16'h100] = 8'h85; seq_dat[16'h101] = 8'h3F;
    seq_dat[16'h200] = 8'h85; seq_dat[16'h201] = 8'h3F;
    set_cfg(0, 0, 0);
    model(4096, 0, 0, 0, esz, ebs, esc);
    drive_download(4096, 1'b0, 1'b0, dv1, dv2);
    total++; if (bus.force_bs !== 4'(ebs)) begin bad++; $display("FAIL 3f_bs got=%0d exp=%0d", bus.force_bs, ebs); end
    total++; if (bus.rom_size !== 17'(esz)) begin bad++; $display("FAIL 3f_size got=%0d exp=%0d", bus.rom_size, esz); end
    total++; if (bus.sc !== 1'(esc)) begin bad++; $display("FAIL 3f_sc got=%0b exp=%0d", bus.sc, esc); end
  endtask

  task automatic test_reset_mid();
    int esz, ebs, esc;
    logic dv1, dv2;
    fill_random(32768);
    set_cfg(0, 0, 0);
    @(negedge clk_sys); bus.ioctl_download = 1'b1;
    repeat (3) @(negedge clk_sys);
    for (int k = 0; k < 5100; k++) begin
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = seq_addr[k]; bus.ioctl_dout = seq_dat[k];
      if (k == 5000) reset = 1'b1;
      if (k == 5003) reset = 1'b0;
    end
    @(negedge clk_sys); bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
    repeat (4) @(negedge clk_sys);
    total++; if (bus.det_valid !== 1'b0) begin bad++; $display("FAIL rmid_dv got=%0b exp=0", bus.det_valid); end
    total++; if (bus.force_bs !== 4'd0) begin bad++; $display("FAIL rmid_bs got=%0d exp=0", bus.force_bs); end
    total++; if (bus.rom_size !== 17'd0) begin bad++; $display("FAIL rmid_size got=%0d exp=0", bus.rom_size); end
    total++; if (bus.sc !== 1'b0) begin bad++; $display("FAIL rmid_sc got=%0b exp=0", bus.sc); end
    model(32768, 0, 0, 0, esz, ebs, esc);
    drive_download(32768, 1'b0, 1'b0, dv1, dv2);
    total++; if (dv2 !== 1'b1) begin bad++; $display("FAIL f4_dv got=%0b exp=1", dv2); end
    total++; if (bus.force_bs !== 4'(ebs)) begin bad++; $display("FAIL f4_bs got=%0d exp=%0d", bus.force_bs, ebs); end
    total++; if (bus.rom_size !== 17'(esz)) begin bad++; $display("FAIL f4_size got=%0d exp=%0d", bus.rom_size, esz); end
  endtask

  task automatic test_empty_then_p2();
    int esz, ebs, esc;
    logic dv1, dv2;
    set_cfg(0, 0, 0);
    model(0, 0, 0, 0, esz, ebs, esc);
    drive_download(0, 1'b0, 1'b0, dv1, dv2);
    total++; if (dv2 !== 1'b1) begin bad++; $display("FAIL empty_dv got=%0b exp=1", dv2); end
    total++; if (bus.rom_size !== 17'(esz)) begin bad++; $display("FAIL empty_size got=%0d exp=%0d", bus.rom_size, esz); end
    total++; if (bus.force_bs !== 4'(ebs)) begin bad++; $display("FAIL empty_bs got=%0d exp=%0d", bus.force_bs, ebs); end
    fill_random(10495);
    seq_dat[16'h800] = 8'h20; seq_dat[16'h801] = 8'h00; seq_dat[16'h802] = 8'hD0;
    seq_dat[16'h803] = 8'hC6; seq_dat[16'h804] = 8'hC5;
    model(10495, 0, 0, 0, esz, ebs, esc);
    drive_download(10495, 1'b1, 1'b0, dv1, dv2);
    total++; if (bus.force_bs !== 4'(ebs)) begin bad++; $display("FAIL p2_bs got=%0d exp=%0d", bus.force_bs, ebs); end
    total++; if (bus.rom_size !== 17'(esz)) begin bad++; $display("FAIL p2_size got=%0d exp=%0d", bus.rom_size, esz); end
  endtask

  task automatic test_out_of_order();
    int esz, ebs, esc;
    logic dv1, dv2;
    for (int k = 0; k < 1024; k++) begin
      seq_addr[k] = (k < 512) ? 17'(512 + k) : 17'(k - 512);
      seq_dat[k]  = rnd_byte();
    end
    seq_dat[511] = 8'h85; seq_dat[512] = 8'h3F;
    seq_dat[700] = 8'h85; seq_dat[701] = 8'h3F;
    set_cfg(0, 0, 0);
    model(1024, 0, 0, 0, esz, ebs, esc);
    drive_download(1024, 1'b0, 1'b0, dv1, dv2);
    total++; if (bus.force_bs !== 4'(ebs)) begin bad++; $display("FAIL ooo_bs got=%0d exp=%0d", bus.force_bs, ebs); end
    total++; if (bus.rom_size !== 17'(esz)) begin bad++; $display("FAIL ooo_size got=%0d exp=%0d", bus.rom_size, esz); end
  endtask

  task automatic test_random();
    int esz, ebs, esc, n, xbs, xsc, mode, pos;
    logic dv1, dv2;
    for (int it = 0; it < 3; it++) begin
      n = int'($urandom_range(256, 600));
      fill_random(n);
      for (int j = int'($urandom_range(0, 3)); j > 0; j--) begin
        pos = int'($urandom_range(0, 250));
        seq_dat[pos] = 8'h85; seq_dat[pos + 1] = 8'h3F;
      end
      if ($urandom_range(0, 1) == 1) for (int k = 0; k < n; k++) seq_dat[k] = 8'h55;
      xbs  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 9)) : 0;
      xsc  = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 3));
      set_cfg(xbs, xsc, mode);
      model(n, xbs, xsc, mode, esz, ebs, esc);
      drive_download(n, 1'(it & 1), 1'b0, dv1, dv2);
      total++; if (bus.force_bs !== 4'(ebs)) begin bad++; $display("FAIL rnd%0d_bs got=%0d exp=%0d", it, bus.force_bs, ebs); end
      total++; if (bus.sc !== 1'(esc)) begin bad++; $display("FAIL rnd%0d_sc got=%0b exp=%0d", it, bus.sc, esc); end
      total++; if (bus.rom_size !== 17'(esz)) begin bad++; $display("FAIL rnd%0d_size got=%0d exp=%0d", it, bus.rom_size, esz); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_e0_8k();
    test_3f_4k();
    test_reset_mid();
    test_empty_then_p2();
    test_out_of_order();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
